// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, taken branch, dmem wait states, dmem timeout.
// Latency: stall/flush combinational, halted_o/stall_cnt_o registered; dmem not-ready holds PC..EX2MEM.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             stall_pc_o,
  output logic             stall_if2id_o,
  output logic             stall_id2ex_o,
  output logic             stall_ex2mem_o,
  output logic             flush_if2id_o,
  output logic             flush_id2ex_o,
  output logic             flush_mem2wb_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT, S_HALT} state_t;

  state_t        state, nxt_state;
  logic [WW-1:0] wait_cnt, nxt_wait_cnt;
  logic          mem_stall;
  logic          load_use;

  assign mem_stall = mem_req_i & ~mem_ready_i;
  assign load_use  = ex_is_load_i & (ex_rd_i != 5'd0) &
                     ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                      (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= S_INIT;
      wait_cnt <= '0;
      halted_o <= 1'b0;
    end else begin
      state    <= nxt_state;
      wait_cnt <= nxt_wait_cnt;
      halted_o <= (nxt_state == S_HALT);
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_wait_cnt = wait_cnt;
    case (state)
      S_INIT: nxt_state = S_RUN;
      S_RUN: begin
        if (mem_stall) begin
          nxt_state    = S_MEM_WAIT;
          nxt_wait_cnt = WW'(1);
        end
      end
      S_MEM_WAIT: begin
        // A dropped request is treated like completion.
        if (!mem_stall) begin
          nxt_state    = S_RUN;
          nxt_wait_cnt = '0;
        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
          nxt_state = S_HALT;
        end else begin
          nxt_wait_cnt = wait_cnt + WW'(1);
        end
      end
      S_HALT: nxt_state = S_HALT;
      default: nxt_state = S_INIT;
    endcase
  end

  always_comb begin
    stall_pc_o     = 1'b0;
    stall_if2id_o  = 1'b0;
    stall_id2ex_o  = 1'b0;
    stall_ex2mem_o = 1'b0;
    flush_if2id_o  = 1'b0;
    flush_id2ex_o  = 1'b0;
    flush_mem2wb_o = 1'b0;
    case (state)
      S_INIT: begin
        stall_pc_o     = 1'b1;
        flush_if2id_o  = 1'b1;
        flush_id2ex_o  = 1'b1;
        flush_mem2wb_o = 1'b1;
      end
      S_RUN, S_MEM_WAIT: begin
        // EX is frozen during a dmem stall, so branch/load-use re-present afterwards.
        if (mem_stall) begin
          stall_pc_o     = 1'b1;
          stall_if2id_o  = 1'b1;
          stall_id2ex_o  = 1'b1;
          stall_ex2mem_o = 1'b1;
          flush_mem2wb_o = 1'b1;
        end else if (ex_br_taken_i) begin
          flush_if2id_o = 1'b1;
          flush_id2ex_o = 1'b1;
        end else if (load_use) begin
          stall_pc_o    = 1'b1;
          stall_if2id_o = 1'b1;
          flush_id2ex_o = 1'b1;
        end
      end
      default: begin
        stall_pc_o     = 1'b1;
        stall_if2id_o  = 1'b1;
        stall_id2ex_o  = 1'b1;
        stall_ex2mem_o = 1'b1;
        flush_mem2wb_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stall_cnt_o <= '0;
    end else if (stall_pc_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counter so saturation is reachable.
module tb_hazard_ctrl;
  localparam int MT = 4;
  localparam int CW = 8;

  // {stall_pc, stall_if2id, stall_id2ex, stall_ex2mem, flush_if2id, flush_id2ex, flush_mem2wb, halted}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_INIT = 8'b1000_1110;
  localparam logic [7:0] V_MEM  = 8'b1111_0010;
  localparam logic [7:0] V_BR   = 8'b0000_1100;
  localparam logic [7:0] V_LU   = 8'b1100_0100;
  localparam logic [7:0] V_HALT = 8'b1111_0011;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, mem_req, mem_ready;
  logic          stall_pc, stall_if2id, stall_id2ex, stall_ex2mem;
  logic          flush_if2id, flush_id2ex, flush_mem2wb, halted;
  logic [CW-1:0] stall_cnt;
  logic [7:0]    outv;
  logic [7:0]    exp_v;
  logic [CW-1:0] exp_cnt;
  int            checks = 0;
  int            errors = 0;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rd_i(ex_rd), .ex_is_load_i(ex_is_load), .ex_br_taken_i(ex_br_taken),
    .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .stall_pc_o(stall_pc), .stall_if2id_o(stall_if2id), .stall_id2ex_o(stall_id2ex),
    .stall_ex2mem_o(stall_ex2mem), .flush_if2id_o(flush_if2id), .flush_id2ex_o(flush_id2ex),
    .flush_mem2wb_o(flush_mem2wb), .halted_o(halted), .stall_cnt_o(stall_cnt)
  );

  always #5 ACLK = ~ACLK;

  assign outv = {stall_pc, stall_if2id, stall_id2ex, stall_ex2mem,
                 flush_if2id, flush_id2ex, flush_mem2wb, halted};

  // Advance one cycle; the counter model counts the cycle that just ended.
  task automatic cyc();
    @(posedge ACLK);
    if (ARESETn && exp_v[7] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic ld, input logic br,
                       input logic mreq, input logic mrdy);
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_br_taken = br; mem_req = mreq; mem_ready = mrdy;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_v = V_INIT; exp_cnt = '0;
    repeat (2) @(posedge ACLK);
    #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL rst_hold out=%b exp=%b", outv, exp_v); end
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL rst_cnt cnt=%0d exp=%0d", stall_cnt, exp_cnt); end
    @(negedge ACLK); ARESETn = 1'b1; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL init_cycle out=%b exp=%b", outv, exp_v); end
    cyc(); exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL run_idle out=%b exp=%b", outv, exp_v); end
    checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL init_cnt cnt=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_load_use();
    drive(5, 1, 0, 0, 5, 1, 0, 0, 0); exp_v = V_LU; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL lu_rs1 out=%b exp=%b", outv, exp_v); end
    cyc(); drive(0, 1, 0, 0, 0, 1, 0, 0, 0); exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL lu_x0 out=%b exp=%b", outv, exp_v); end
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt cnt=%0d exp=%0d", stall_cnt, exp_cnt); end
    cyc(); drive(3, 1, 7, 1, 7, 1, 0, 0, 0); exp_v = V_LU; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL lu_rs2 out=%b exp=%b", outv, exp_v); end
    cyc(); drive(5, 0, 0, 0, 5, 1, 0, 0, 0); exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL lu_unused out=%b exp=%b", outv, exp_v); end
    cyc(); drive(5, 1, 0, 0, 5, 0, 0, 0, 0); exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL lu_noload out=%b exp=%b", outv, exp_v); end
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt2 cnt=%0d exp=%0d", stall_cnt, exp_cnt); end
    cyc();
  endtask

  task automatic test_branch();
    drive(5, 1, 0, 0, 5, 1, 1, 0, 0); exp_v = V_BR; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL br_over_lu out=%b exp=%b", outv, exp_v); end
    cyc(); drive(0, 0, 0, 0, 0, 0, 1, 0, 0); exp_v = V_BR; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL br_only out=%b exp=%b", outv, exp_v); end
    cyc();
  endtask

  task automatic test_mem_wait();
    logic [CW-1:0] base;
    base = exp_cnt;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); exp_v = V_MEM;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outv !== exp_v) begin errors++; $display("FAIL mem_stall%0d out=%b exp=%b", i, outv, exp_v); end
      cyc();
    end
    mem_ready = 1'b1; exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL mem_ready_drop out=%b exp=%b", outv, exp_v); end
    checks++; if (stall_cnt !== base + 8'd3) begin errors++; $display("FAIL mem_cnt cnt=%0d exp=%0d", stall_cnt, base + 8'd3); end
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL mem_back_run out=%b exp=%b", outv, exp_v); end
    cyc();
  endtask

  task automatic test_branch_in_mem_stall();
    drive(5, 1, 0, 0, 5, 1, 1, 1, 0); exp_v = V_MEM; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL brmem_a out=%b exp=%b", outv, exp_v); end
    cyc(); #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL brmem_b out=%b exp=%b", outv, exp_v); end
    cyc(); mem_ready = 1'b1; exp_v = V_BR; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL brmem_release out=%b exp=%b", outv, exp_v); end
    cyc();
  endtask

  task automatic test_req_drop();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); exp_v = V_MEM; #1;
    cyc(); mem_req = 1'b0; exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL reqdrop out=%b exp=%b", outv, exp_v); end
    cyc(); mem_req = 1'b1; exp_v = V_MEM; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL reqdrop_again out=%b exp=%b", outv, exp_v); end
    cyc(); mem_ready = 1'b1; exp_v = V_IDLE; #1;
    cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); exp_v = V_MEM; #1;
    cyc(); cyc(); #2;
    ARESETn = 1'b0; exp_v = V_INIT; exp_cnt = '0; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL midrst out=%b exp=%b", outv, exp_v); end
    checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL midrst_cnt cnt=%0d exp=0", stall_cnt); end
    @(negedge ACLK); ARESETn = 1'b1; mem_req = 1'b0; #1;
    cyc(); exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL midrst_run out=%b exp=%b", outv, exp_v); end
  endtask

  task automatic test_timeout();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); exp_v = V_MEM;
    for (int i = 0; i < MT; i++) begin
      #1;
      checks++; if (outv !== exp_v) begin errors++; $display("FAIL to_wait%0d out=%b exp=%b", i, outv, exp_v); end
      cyc();
    end
    exp_v = V_HALT; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL to_halt out=%b exp=%b", outv, exp_v); end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1); #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL halt_sticky out=%b exp=%b", outv, exp_v); end
    repeat (300) cyc();
    #1;
    checks++; if (stall_cnt !== 8'hFF || exp_cnt !== 8'hFF) begin errors++; $display("FAIL cnt_sat cnt=%0d exp=255", stall_cnt); end
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL halt_hold out=%b exp=%b", outv, exp_v); end
    ARESETn = 1'b0; exp_v = V_INIT; exp_cnt = '0; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL halt_rst out=%b exp=%b", outv, exp_v); end
    @(negedge ACLK); ARESETn = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL halt_init out=%b exp=%b", outv, exp_v); end
    cyc(); exp_v = V_IDLE; #1;
    checks++; if (outv !== exp_v) begin errors++; $display("FAIL post_halt_run out=%b exp=%b", outv, exp_v); end
    checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL post_halt_cnt cnt=%0d exp=1", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_in_mem_stall();
    test_req_drop();
    test_reset_mid_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
